// File: rtl/axil_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_pkg
// Purpose  : Shared definitions for the AXI4-Lite register bank slave.
//            This package holds the AXI response codes, the write-channel and
//            read-channel state encodings, and the helper function that finds
//            the register-index LSB for a given bus width.
// Revision : 1.0 - initial release
// ============================================================================
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Number of byte-offset address bits below the register index.
  function automatic int unsigned idx_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_regbank_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_wr_fsm
// Purpose  : AXI4-Lite write channel for the register bank. It accepts AW and
//            W in either order or together, holds whichever arrives first, and
//            decodes the target. It then issues a single-cycle commit toward
//            the register array and returns the write response.
// Ports    : clk, rst             - clock, async active-high reset
//            awaddr/awvalid/awready, wdata/wstrb/wvalid/wready - AXI inputs
//            bresp/bvalid/bready  - AXI write response
//            commit_o             - legal write commits at the coming edge
//            commit_idx_o         - target register index
//            commit_data_o        - write data
//            commit_mask_o        - byte strobes expanded to a bit mask
// Config   : AXIL_REGBANK_IRQ_EN makes index NUM_REGS (pending) writable.
// Revision : 1.0 - initial release
// ============================================================================
module axil_regbank_wr_fsm
  import axil_regbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned NUM_RO     = 2,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned IDX_LSB    = idx_lsb(DATA_WIDTH),
  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - IDX_LSB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic                  commit_o,
  output logic [IDX_WIDTH-1:0]  commit_idx_o,
  output logic [DATA_WIDTH-1:0] commit_data_o,
  output logic [DATA_WIDTH-1:0] commit_mask_o
);

  wr_state_e             state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, fire, legal;
  logic [IDX_WIDTH-1:0]  aw_idx, eff_idx;
  logic [DATA_WIDTH-1:0] eff_data;
  logic [STRB_WIDTH-1:0] eff_strb;
  logic [31:0]           eff_idx_ext;
  logic                  unused_addr_lsb;

  assign awready_o = (state_q == W_IDLE) || (state_q == W_HAVE_D);
  assign wready_o  = (state_q == W_IDLE) || (state_q == W_HAVE_A);
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign bvalid_o  = (state_q == W_RESP);
  assign bresp_o   = bresp_q;

  assign aw_idx          = awaddr_i[ADDR_WIDTH-1:IDX_LSB];
  assign unused_addr_lsb = ^awaddr_i[IDX_LSB-1:0];

  // Whichever half was captured earlier comes from the holding registers,
  // the other half comes straight off the bus in the completing cycle.
  assign eff_idx  = (state_q == W_HAVE_A) ? idx_q  : aw_idx;
  assign eff_data = (state_q == W_HAVE_D) ? data_q : wdata_i;
  assign eff_strb = (state_q == W_HAVE_D) ? strb_q : wstrb_i;

  assign fire = ((state_q == W_IDLE)   && aw_hs && w_hs) ||
                ((state_q == W_HAVE_A) && w_hs) ||
                ((state_q == W_HAVE_D) && aw_hs);

  assign eff_idx_ext = 32'(eff_idx);

`ifdef AXIL_REGBANK_IRQ_EN
  assign legal = (eff_idx_ext < (NUM_REGS - NUM_RO)) || (eff_idx_ext == NUM_REGS);
`else
  assign legal = (eff_idx_ext < (NUM_REGS - NUM_RO));
`endif

  assign commit_o      = fire && legal;
  assign commit_idx_o  = eff_idx;
  assign commit_data_o = eff_data;

  for (genvar k = 0; k < STRB_WIDTH; k++) begin : g_mask
    assign commit_mask_o[k*8 +: 8] = {8{eff_strb[k]}};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    strb_d  = strb_q;
    bresp_d = bresp_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = W_RESP;
        end else if (aw_hs) begin
          state_d = W_HAVE_A;
          idx_d   = aw_idx;
        end else if (w_hs) begin
          state_d = W_HAVE_D;
          data_d  = wdata_i;
          strb_d  = wstrb_i;
        end
      end
      W_HAVE_A: if (w_hs)     state_d = W_RESP;
      W_HAVE_D: if (aw_hs)    state_d = W_RESP;
      W_RESP:   if (bready_i) state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
    if (fire) bresp_d = legal ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      bresp_q <= bresp_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_slave
// Purpose  : Parametrised AXI4-Lite register bank. The low slots are
//            read-write with byte strobes, and the top NUM_RO slots are
//            read-only status windows. Out-of-range or read-only writes are
//            rejected with SLVERR. Each successful write produces a one-cycle
//            pulse on its register.
// Ports    : ACLK, ARESET        - clock, async active-high reset
//            s_axi_*             - AXI4-Lite slave (prot ignored)
//            reg_o               - flattened registers, RO slots read as 0
//            status_i            - sources for the read-only slots
//            wr_pulse_o          - per-register write strobe
//            irq_o               - status-edge interrupt
// Config   : AXIL_REGBANK_IRQ_EN adds a W1C pending register at index NUM_REGS
//            set by rising edges of bit 0 of each status word. When the macro
//            is undefined, irq_o is tied low and that index decodes as SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axil_regbank_slave
  import axil_regbank_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           NUM_REGS   = 8,
  parameter int unsigned           NUM_RO     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   status_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  output logic                           irq_o
);

  localparam int unsigned IDX_LSB   = idx_lsb(DATA_WIDTH);
  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - IDX_LSB;
  localparam int unsigned NUM_RW    = NUM_REGS - NUM_RO;

  logic                  commit;
  logic [IDX_WIDTH-1:0]  commit_idx;
  logic [DATA_WIDTH-1:0] commit_data, commit_mask;
  logic [31:0]           commit_idx_ext;

  logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [DATA_WIDTH-1:0] regs_d [NUM_RW];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  rd_state_e             r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux_data;
  logic [1:0]            rresp_q, rresp_d, rd_mux_resp;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic [31:0]           ar_idx_ext;
  logic                  unused_inputs;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[IDX_LSB-1:0]};

  axil_regbank_wr_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .NUM_RO     (NUM_RO)
  ) u_wr_fsm (
    .clk           (ACLK),
    .rst           (ARESET),
    .awaddr_i      (s_axi_awaddr),
    .awvalid_i     (s_axi_awvalid),
    .awready_o     (s_axi_awready),
    .wdata_i       (s_axi_wdata),
    .wstrb_i       (s_axi_wstrb),
    .wvalid_i      (s_axi_wvalid),
    .wready_o      (s_axi_wready),
    .bresp_o       (s_axi_bresp),
    .bvalid_o      (s_axi_bvalid),
    .bready_i      (s_axi_bready),
    .commit_o      (commit),
    .commit_idx_o  (commit_idx),
    .commit_data_o (commit_data),
    .commit_mask_o (commit_mask)
  );

  assign commit_idx_ext = 32'(commit_idx);

  // --------------------------------------------------------------------------
  // Read-write register array and write pulses
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_RW; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (commit_idx_ext == 32'(i)))
        regs_d[i] = (regs_q[i] & ~commit_mask) | (commit_data & commit_mask);
    end
    for (int i = 0; i < NUM_REGS; i++)
      wr_pulse_d[i] = commit && (commit_idx_ext == 32'(i));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RESET_VAL;
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign wr_pulse_o = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_o
    if (i < NUM_RW) begin : g_rw
      assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end else begin : g_ro
      assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt pending register
  // --------------------------------------------------------------------------
`ifdef AXIL_REGBANK_IRQ_EN
  logic [NUM_RO-1:0] stat0_q, stat0_d, pending_q, pending_d, pend_clr;
  logic              irq_q, irq_d;

  always_comb begin
    for (int j = 0; j < NUM_RO; j++) stat0_d[j] = status_i[j*DATA_WIDTH];
    pend_clr = '0;
    if (commit && (commit_idx_ext == NUM_REGS))
      pend_clr = commit_data[NUM_RO-1:0] & commit_mask[NUM_RO-1:0];
    // Set is OR-ed in after the clear so a coincident edge is never lost.
    pending_d = (pending_q & ~pend_clr) | (stat0_d & ~stat0_q);
    irq_d     = |pending_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stat0_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      stat0_q   <= stat0_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read channel: data is sampled from pre-edge register contents, so a
  // read that coincides with a write returns the old value.
  // --------------------------------------------------------------------------
  assign ar_idx     = s_axi_araddr[ADDR_WIDTH-1:IDX_LSB];
  assign ar_idx_ext = 32'(ar_idx);

  always_comb begin
    rd_mux_data = '0;
    rd_mux_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (ar_idx_ext == 32'(i)) begin
        rd_mux_data = regs_q[i];
        rd_mux_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (ar_idx_ext == 32'(NUM_RW + j)) begin
        rd_mux_data = status_i[j*DATA_WIDTH +: DATA_WIDTH];
        rd_mux_resp = RESP_OKAY;
      end
    end
`ifdef AXIL_REGBANK_IRQ_EN
    if (ar_idx_ext == NUM_REGS) begin
      rd_mux_data = DATA_WIDTH'(pending_q);
      rd_mux_resp = RESP_OKAY;
    end
`endif
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_state_d = R_DATA;
          rdata_d   = rd_mux_data;
          rresp_d   = rd_mux_resp;
        end
      end
      R_DATA:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
`default_nettype wire
